cluster_count_monitor: RTL

Sits directly downstream of the 768-strip cluster counter and consumes its registered count and overflow flag at clock4x, four samples per bunch crossing (BX). Reduces the samples to per-BX results: the maximum count and the OR of the overflow flags. Accumulates windowed monitoring counters and hands a snapshot to slow control through a request/valid/ack handshake.

---
 rtl/cluster_count_monitor.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cluster_count_monitor.sv
// -----------------------------------------------------------------------------
// cluster_count_monitor
//
// Consumes the registered cluster count and overflow flag of the 768-strip
// cluster counter at clock4x (four samples per bunch crossing). It reduces the
// samples to one result per BX: the maximum count and the OR of the overflow
// flags. It also keeps saturating window counters and hands a snapshot of them
// to slow control through a request / valid / ack handshake.
//
// Ports
//   clock4x       in   4x BX clock, the only clock
//   reset_n       in   asynchronous active-low reset
//   cnt_i         in   cluster count sample, one per clock4x
//   overflow_i    in   overflow flag aligned with cnt_i
//   bx_strobe_i   in   marks this cycle's sample as phase 0 of a new BX
//   bx_max_o      out  maximum cnt_i over the last closed BX
//   bx_ovf_o      out  OR of overflow_i over the last closed BX
//   bx_valid_o    out  one-cycle pulse, bx_max_o/bx_ovf_o updated this cycle
//   snap_req_i    in   pulse requesting a window snapshot
//   snap_ack_i    in   consumer has taken the snapshot
//   snap_valid_o  out  snapshot outputs are stable and valid
//   snap_nbx_o    out  number of BXs closed in the window
//   snap_novf_o   out  number of BXs with bx_ovf set
//   snap_sum_o    out  sum of bx_max over the window
//   phase_err_o   out  sticky: a strobe arrived while phase_q != 0
// -----------------------------------------------------------------------------
module cluster_count_monitor #(
    parameter int CNT_WIDTH = 11,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clock4x,
    input  logic                 reset_n,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 overflow_i,
    input  logic                 bx_strobe_i,
    output logic [CNT_WIDTH-1:0] bx_max_o,
    output logic                 bx_ovf_o,
    output logic                 bx_valid_o,
    input  logic                 snap_req_i,
    input  logic                 snap_ack_i,
    output logic                 snap_valid_o,
    output logic [ACC_WIDTH-1:0] snap_nbx_o,
    output logic [ACC_WIDTH-1:0] snap_novf_o,
    output logic [ACC_WIDTH-1:0] snap_sum_o,
    output logic                 phase_err_o
);

    // Snapshot handshake states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Adder width for saturation: one bit wider than the wider operand so the
    // carry out is never lost before the limit compare.
    localparam int SUM_W = ((ACC_WIDTH > CNT_WIDTH) ? ACC_WIDTH : CNT_WIDTH) + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    // Saturating add: the window counters pin at all-ones and never wrap.
    function automatic logic [ACC_WIDTH-1:0] sat_add(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [SUM_W-1:0]     inc
    );
        logic [SUM_W-1:0] total;
        total = SUM_W'(acc) + inc;
        if (total > SUM_W'(ACC_MAX)) begin
            return ACC_MAX;
        end
        return total[ACC_WIDTH-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]           phase_q,     phase_d;
    logic                 bx_open_q,   bx_open_d;
    logic [CNT_WIDTH-1:0] max_acc_q,   max_acc_d;
    logic                 ovf_acc_q,   ovf_acc_d;

    logic [CNT_WIDTH-1:0] bx_max_q,    bx_max_d;
    logic                 bx_ovf_q,    bx_ovf_d;
    logic                 bx_valid_q,  bx_valid_d;
    logic                 phase_err_q, phase_err_d;

    logic [ACC_WIDTH-1:0] nbx_q,       nbx_d;
    logic [ACC_WIDTH-1:0] novf_q,      novf_d;
    logic [ACC_WIDTH-1:0] sum_q,       sum_d;

    logic [1:0]           state_q,     state_d;
    logic [ACC_WIDTH-1:0] snap_nbx_q,  snap_nbx_d;
    logic [ACC_WIDTH-1:0] snap_novf_q, snap_novf_d;
    logic [ACC_WIDTH-1:0] snap_sum_q,  snap_sum_d;

    // -------------------------------------------------------------------------
    // Phase tracking and BX boundary detection
    // -------------------------------------------------------------------------
    logic [1:0] ph;         // effective phase of the sample in this cycle
    logic       ph_zero;
    logic       bx_close;   // the BX collected so far ends on this cycle
    logic       short_bx;   // strobe arrived before the BX had four samples
    logic       snap_latch; // snapshot captured on this cycle

    // A strobe forces this sample to phase 0; otherwise the phase free-runs.
    assign ph       = bx_strobe_i ? 2'd0 : phase_q;
    assign ph_zero  = (ph == 2'd0);
    // The very first phase 0 after reset has nothing collected to close.
    assign bx_close = ph_zero && bx_open_q;
    assign short_bx = bx_strobe_i && (phase_q != 2'd0);

    // Two-bit phase wraps 3 -> 0 on its own.
    assign phase_d   = ph + 2'd1;
    assign bx_open_d = 1'b1;

    // Per-BX reduction: phase 0 restarts the running max/OR with this sample.
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        max_acc_d = max_acc_q;
        ovf_acc_d = ovf_acc_q;
        if (ph_zero) begin
            max_acc_d = cnt_i;
            ovf_acc_d = overflow_i;
        end else begin
            if (cnt_i > max_acc_q) begin
                max_acc_d = cnt_i;
            end
            ovf_acc_d = ovf_acc_q | overflow_i;
        end
    end

    // Per-BX result registers: the accumulators still hold the closing BX on
    // the close cycle, so they are captured before being reloaded.
    always_comb begin
        bx_max_d   = bx_max_q;
        bx_ovf_d   = bx_ovf_q;
        bx_valid_d = bx_close;
        if (bx_close) begin
            bx_max_d = max_acc_q;
            bx_ovf_d = ovf_acc_q;
        end
    end

    // -------------------------------------------------------------------------
    // Window counters and snapshot handshake
    // -------------------------------------------------------------------------
    always_comb begin
        nbx_d       = nbx_q;
        novf_d      = novf_q;
        sum_d       = sum_q;
        state_d     = state_q;
        snap_nbx_d  = snap_nbx_q;
        snap_novf_d = snap_novf_q;
        snap_sum_d  = snap_sum_q;
        snap_latch  = 1'b0;

        // Counters run in every state, including while a snapshot is held.
        if (bx_close) begin
            nbx_d  = sat_add(nbx_q,  SUM_W'(1));
            novf_d = sat_add(novf_q, SUM_W'(ovf_acc_q));
            sum_d  = sat_add(sum_q,  SUM_W'(max_acc_q));
        end

        case (state_q)
            ST_IDLE: begin
                // A request on a close cycle only arms: the capture happens on
                // the following close, seen from ARMED.
                if (snap_req_i) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bx_close) begin
                    // The closing BX belongs to the old window: capture the
                    // updated counters, then start the new window from zero.
                    snap_nbx_d  = nbx_d;
                    snap_novf_d = novf_d;
                    snap_sum_d  = sum_d;
                    nbx_d       = '0;
                    novf_d      = '0;
                    sum_d       = '0;
                    snap_latch  = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Requests arriving here are dropped; they never queue.
                if (snap_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky phase error: cleared by a snapshot latch, but a short BX on the
    // same cycle still records the error so it is never lost.
    always_comb begin
        phase_err_d = phase_err_q;
        if (snap_latch) begin
            phase_err_d = 1'b0;
        end
        if (short_bx) begin
            phase_err_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: the data registers are reset too, not only the control state,
    // because every output, snapshot data included, must read zero in reset.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= 2'd0;
            bx_open_q   <= 1'b0;
            max_acc_q   <= '0;
            ovf_acc_q   <= 1'b0;
            bx_max_q    <= '0;
            bx_ovf_q    <= 1'b0;
            bx_valid_q  <= 1'b0;
            phase_err_q <= 1'b0;
            nbx_q       <= '0;
            novf_q      <= '0;
            sum_q       <= '0;
            state_q     <= ST_IDLE;
            snap_nbx_q  <= '0;
            snap_novf_q <= '0;
            snap_sum_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            phase_q     <= phase_d;
            bx_open_q   <= bx_open_d;
            max_acc_q   <= max_acc_d;
            ovf_acc_q   <= ovf_acc_d;
            bx_max_q    <= bx_max_d;
            bx_ovf_q    <= bx_ovf_d;
            bx_valid_q  <= bx_valid_d;
            phase_err_q <= phase_err_d;
            nbx_q       <= nbx_d;
            novf_q      <= novf_d;
            sum_q       <= sum_d;
            state_q     <= state_d;
            snap_nbx_q  <= snap_nbx_d;
            snap_novf_q <= snap_novf_d;
            snap_sum_q  <= snap_sum_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bx_max_o     = bx_max_q;
    assign bx_ovf_o     = bx_ovf_q;
    assign bx_valid_o   = bx_valid_q;
    assign phase_err_o  = phase_err_q;
    assign snap_valid_o = (state_q == ST_HOLD);
    assign snap_nbx_o   = snap_nbx_q;
    assign snap_novf_o  = snap_novf_q;
    assign snap_sum_o   = snap_sum_q;

endmodule
